// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared ALU control codes, widths and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 4;

    // ALU control codes; anything above ALU_CTRL_MAX is illegal.
    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] ALU_SUB      = 4'b0001;
    localparam logic [3:0] ALU_AND      = 4'b0010;
    localparam logic [3:0] ALU_OR       = 4'b0011;
    localparam logic [3:0] ALU_XOR      = 4'b0100;
    localparam logic [3:0] ALU_SLL      = 4'b0101;
    localparam logic [3:0] ALU_SRL      = 4'b0110;
    localparam logic [3:0] ALU_SRA      = 4'b0111;
    localparam logic [3:0] ALU_SLT      = 4'b1000;
    localparam logic [3:0] ALU_SLTU     = 4'b1001;
    localparam logic [3:0] ALU_CTRL_MAX = 4'b1001;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker. A lone requester wins outright;
//               on a tie the port that did not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_id_i,
    output logic [1:0] grant_o,
    output logic       id_o
);

    // Pick the winner from the current request vector and the last grantee.
    always_comb begin
        grant_o = 2'b00;
        id_o    = 1'b0;
        case (valid_i)
            2'b01: begin
                grant_o = 2'b01;
                id_o    = 1'b0;
            end
            2'b10: begin
                grant_o = 2'b10;
                id_o    = 1'b1;
            end
            2'b11: begin
                grant_o = last_id_i ? 2'b01 : 2'b10;
                id_o    = ~last_id_i;
            end
            default: begin
                grant_o = 2'b00;
                id_o    = 1'b0;
            end
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one external RV32I ALU between the execute stage
//               (port 0) and the address/branch-compare unit (port 1).
//               Operands are registered toward the ALU, the result is
//               captured one cycle later and held on a backpressured
//               response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN   = alu_pkg::XLEN,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    // Port 0 (execute stage)
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [XLEN-1:0]   r0_a,
    input  logic [XLEN-1:0]   r0_b,
    input  logic [CTRL_W-1:0] r0_ctrl,
    // Port 1 (address/branch-compare unit)
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [XLEN-1:0]   r1_a,
    input  logic [XLEN-1:0]   r1_b,
    input  logic [CTRL_W-1:0] r1_ctrl,
    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_result,
    output logic              rsp_id,
    output logic              rsp_err,
    // External ALU
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   alu_result,
    // Status
    output logic              busy
);

    localparam logic [CTRL_W-1:0] CTRL_MAX = CTRL_W'(ALU_CTRL_MAX);

    arb_state_e        state_q;
    logic              last_id_q;
    logic              id_q;
    logic [XLEN-1:0]   alu_a_q;
    logic [XLEN-1:0]   alu_b_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_result_q;
    logic              rsp_id_q;
    logic              rsp_err_q;

    logic [1:0]        grant;
    logic              win_id;
    logic              accept;
    logic              ctrl_legal;

    rr_arb2 u_rr_arb2 (
        .valid_i   ({r1_valid, r0_valid}),
        .last_id_i (last_id_q),
        .grant_o   (grant),
        .id_o      (win_id)
    );

    // Ready is offered only while idle, and only to the winning port; it is
    // also held low while reset is asserted so every output reads zero then.
    always_comb begin
        r0_ready   = rst_n && (state_q == IDLE) && grant[0];
        r1_ready   = rst_n && (state_q == IDLE) && grant[1];
        accept     = r0_ready || r1_ready;
        ctrl_legal = (alu_ctrl_q <= CTRL_MAX);
    end

    // Sequencer: accept one request, let the ALU settle for a cycle, then
    // hold the captured result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_id_q    <= 1'b1;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q    <= win_id ? r1_a    : r0_a;
                        alu_b_q    <= win_id ? r1_b    : r0_b;
                        alu_ctrl_q <= win_id ? r1_ctrl : r0_ctrl;
                        id_q       <= win_id;
                        last_id_q  <= win_id;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal codes never let ALU output escape.
                    rsp_result_q <= ctrl_legal ? alu_result : '0;
                    rsp_err_q    <= ~ctrl_legal;
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Registered values drive the outputs directly.
    always_comb begin
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        alu_ctrl   = alu_ctrl_q;
        rsp_valid  = rsp_valid_q;
        rsp_result = rsp_result_q;
        rsp_id     = rsp_id_q;
        rsp_err    = rsp_err_q;
        busy       = (state_q != IDLE);
    end

endmodule : alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single RV32I ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch-compare unit. Each port uses a valid/ready handshake. The arbiter grants one request at a time, round-robin, and registers the operands into the ALU. It captures the result and returns it on a single response channel with backpressure. The ALU itself stays outside this block; the arbiter drives its a/b/alu_ctrl inputs and samples its combinational result.

Parameters:
XLEN, 32, operand/result width
CTRL_W, 4, ALU control code width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
r0_valid  in  1  port 0 request valid
r0_ready  out  1  port 0 request accepted this cycle
r0_a  in  XLEN  port 0 operand a
r0_b  in  XLEN  port 0 operand b
r0_ctrl  in  CTRL_W  port 0 ALU control code
r1_valid / r1_ready / r1_a / r1_b / r1_ctrl  same as port 0, for port 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_result  out  XLEN  ALU result
rsp_id  out  1  port that issued the request (0/1)
rsp_err  out  1  illegal ctrl code (result forced 0)
alu_a  out  XLEN  to ALU operand a
alu_b  out  XLEN  to ALU operand b
alu_ctrl  out  CTRL_W  to ALU control
alu_result  in  XLEN  from ALU result (combinational)
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE, round-robin pointer last_id = 1, so port 0 wins first.
  - All outputs 0: r*_ready, rsp_valid, rsp_result, rsp_id, rsp_err, alu_a, alu_b, alu_ctrl, busy.
- Legal ctrl codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU. Codes 1010-1111 are illegal.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - r*_ready is combinational and asserted only in IDLE, to the single winning port.
  - Winner selection: if only one port is valid, it wins. If both are valid, the port != last_id wins.
  - On handshake: latch a/b/ctrl into alu_a/alu_b/alu_ctrl, latch id, set last_id = id, go to EXEC.
- EXEC (one cycle):
  - alu_* hold steady.
  - At the clock edge, capture rsp_result = alu_result, or 0 with rsp_err = 1 if ctrl is illegal. Capture rsp_id.
  - Set rsp_valid = 1 and go to RESP.
- RESP:
  - rsp_valid, rsp_result, rsp_id and rsp_err hold stable until rsp_ready = 1.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE. Nothing new is accepted in this cycle.
- Latency:
  - Accept at edge T, rsp_valid visible after edge T+1.
  - Minimum issue interval is 3 cycles when rsp_ready is tied high.
- alu_a, alu_b and alu_ctrl keep their last values outside EXEC. They are not cleared.
- Requester inputs may change freely while r*_ready = 0. Only the values present at the handshake edge are used.
- A port dropping valid before it is granted is legal; that request is simply never issued.
- Both ports valid back-to-back: grants strictly alternate (0,1,0,1...).
- Reset asserted mid-operation (EXEC or RESP):
  - Asynchronous return to IDLE with all outputs at reset values.
  - The in-flight response is discarded and never presented.
- Arithmetic is performed only by the ALU. The arbiter neither widens nor modifies data, apart from forcing the result to 0 on an illegal code.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_* ctrl code constants (4-bit values above) and ALU_CTRL_MAX = 4'b1001.
  - XLEN default.
  - State encoding: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
- One natural sub-module: rr_arb2, a 2-way round-robin picker. Inputs valid[1:0] and last_id; outputs grant[1:0] (one-hot) and id.
- The ALU instance is placed by the parent, not inside this block.

Test Plan:
- Port 0 only: r0_a = 5, r0_b = 3, ctrl = 0000, rsp_ready = 1 -> r0_ready high in IDLE; rsp_valid 2 cycles after accept; rsp_result = 8, rsp_id = 0, rsp_err = 0.
- Both ports valid simultaneously from reset: r0 = SUB(5,7), r1 = SLTU(0xFFFFFFFB,3) -> first response id 0 with result 0xFFFFFFFE; second response id 1 with result 0. Grants alternate 0,1,0,1 over 4 further paired requests.
- Backpressure: r1 = SRA(0xFFFFFFF8,1), rsp_ready held low 5 cycles -> rsp_valid stays high with result 0xFFFFFFFC stable; r0_ready and r1_ready stay 0 throughout; IDLE is re-entered the cycle after rsp_ready rises.
- Illegal ctrl: r0 = ctrl 1100, a = 0xF0F0F0F0, b = 0x0F0F0F0F -> rsp_err = 1, rsp_result = 0, rsp_id = 0; the next legal OR request returns 0xFFFFFFFF with rsp_err = 0.
- Reset in RESP: accept SLL(1,4), pull rst_n low while rsp_valid = 1 -> all outputs 0 immediately (asynchronous); after release, no stale response appears; a new ADD(2,2) returns 4 with id 0.
- Request withdrawal: r1_valid pulses for 1 cycle while busy -> that request is never granted; no response carries id 1.
